// File: rtl/twos_comp_decoder_if.sv
// twos_comp_decoder_if: valid/ready handshake bundle for the two's-complement decoder.
// master = upstream producer / downstream consumer side, slave = decoder side.
interface twos_comp_decoder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, err
    );
endinterface

// File: rtl/twos_comp_decoder.sv
// twos_comp_decoder: bit-serial two's-complement decoder. Re-negates the accepted
// word LSB-first (copy bits up to and including the first 1, invert the rest) and
// flags decoded values >= BCD_LIMIT on err.
// Optional feature macro: TWOS_DEC_ERR_STICKY_EN adds clr_err / err_sticky.
module twos_comp_decoder #(
    parameter int WIDTH     = 4,
    parameter int BCD_LIMIT = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    twos_comp_decoder_if.slave bus,
`ifdef TWOS_DEC_ERR_STICKY_EN
    input  logic               clr_err,
    output logic               err_sticky,
`endif
    output logic               busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] nxt_res;
    logic [WIDTH-1:0] out_data_q;
    logic [CW-1:0]    cnt;
    logic             seen_one;
    logic             err_q;
    logic             armed;
    logic             in_ready_c;
    logic             accept;
    logic             last_bit;
    logic             rbit;
    logic             nxt_err;

    // Serial negation step and handshake qualifiers
    always_comb begin
        rbit     = sreg[0] ^ seen_one;
        nxt_res  = {rbit, res[WIDTH-1:1]};
        nxt_err  = (32'(nxt_res) >= 32'(BCD_LIMIT));
        last_bit = (cnt == CW'(WIDTH - 1));
        accept   = bus.in_valid && in_ready_c;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = SHIFT;
            SHIFT:   if (last_bit)      state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Outputs; in_ready is also gated by armed so it stays low until the first edge after reset
    always_comb begin
        in_ready_c    = (state == IDLE) && armed;
        bus.in_ready  = in_ready_c;
        bus.out_valid = (state == DONE);
        bus.out_data  = out_data_q;
        bus.err       = err_q;
        busy          = (state == SHIFT);
    end

    // Datapath: latch on accept, shift one bit per SHIFT cycle, capture result on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            sreg       <= '0;
            res        <= '0;
            cnt        <= '0;
            seen_one   <= 1'b0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg     <= bus.in_data;
                        res      <= '0;
                        cnt      <= '0;
                        seen_one <= 1'b0;
                    end
                end
                SHIFT: begin
                    sreg     <= {1'b0, sreg[WIDTH-1:1]};
                    res      <= nxt_res;
                    seen_one <= seen_one | sreg[0];
                    if (last_bit) begin
                        out_data_q <= nxt_res;
                        err_q      <= nxt_err;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TWOS_DEC_ERR_STICKY_EN
    // Sticky error: set on an err=1 DONE entry, cleared by clr_err; set has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if ((state == SHIFT) && last_bit && nxt_err) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_twos_comp_decoder.sv
// tb_twos_comp_decoder: scoreboard bench for twos_comp_decoder (WIDTH=4, BCD_LIMIT=9).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_twos_comp_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef TWOS_DEC_ERR_STICKY_EN
    logic clr_err = 1'b0;
    logic err_sticky;
`endif

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];

    twos_comp_decoder_if #(.WIDTH(4)) bus ();

    twos_comp_decoder #(.WIDTH(4), .BCD_LIMIT(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
`ifdef TWOS_DEC_ERR_STICKY_EN
        .clr_err    (clr_err),
        .err_sticky (err_sticky),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: {err, value} with value = -x mod 16
    function automatic logic [4:0] model(input logic [3:0] x);
        logic [3:0] d;
        d = 4'd0 - x;
        return {(d >= 4'd9), d};
    endfunction

    // Present x until accepted, push its expected result; returns on the negedge after the accept edge
    task automatic accept_word(input logic [3:0] x);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
        end else begin
            exp_q.push_back(model(x));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
    endtask

    // Count edges from the accept edge (inclusive) until out_valid is seen
    task automatic wait_out(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Handshake the current output, returning {err, out_data}
    task automatic take(output logic [4:0] got);
        bus.out_ready = 1'b1;
        got = {bus.err, bus.out_data};
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.err, busy} !== 8'h00) begin
            bad++;
            $display("FAIL reset_values got=%b required=00000000",
                     {bus.in_ready, bus.out_valid, bus.out_data, bus.err, busy});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%b required=0", bus.in_ready);
        end
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge got=%b required=1", bus.in_ready);
        end
    endtask

    task automatic test_latency();
        int lat;
        logic [4:0] got;
        logic [4:0] e;
        accept_word(4'b1100);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_shift got=%b required=1", busy);
        end
        wait_out(lat);
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL latency got=%0d required=5", lat);
        end
        total++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_flags in_ready=%b busy=%b required=0,0", bus.in_ready, busy);
        end
        take(got);
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL decode_1100 got=%h required=%h", got, e);
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL return_idle out_valid=%b in_ready=%b required=0,1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_all_values();
        int lat;
        logic [4:0] got;
        logic [4:0] e;
        for (int v = 0; v < 16; v++) begin
            accept_word(4'(v));
            wait_out(lat);
            total++;
            if (lat != 5) begin
                bad++;
                $display("FAIL value_latency in=%0d got=%0d required=5", v, lat);
            end
            if (bus.out_valid === 1'b1) begin
                take(got);
                e = exp_q.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL decode in=%h got=%h required=%h", v, got, e);
                end
            end else begin
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [4:0] held;
        logic [4:0] got;
        logic [4:0] e;
        accept_word(4'b0111);
        wait_out(lat);
        held = {bus.err, bus.out_data};
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0011;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({bus.out_valid, bus.in_ready, bus.err, bus.out_data} !== {2'b10, held}) begin
                bad++;
                $display("FAIL hold_stable cycle=%0d got=%b required=%b", c,
                         {bus.out_valid, bus.in_ready, bus.err, bus.out_data}, {2'b10, held});
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        take(got);
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL hold_decode got=%h required=%h", got, e);
        end
        total++;
        if ({bus.out_valid, bus.in_ready, busy, bus.err, bus.out_data} !== {3'b010, e}) begin
            bad++;
            $display("FAIL hold_release got=%b required=%b",
                     {bus.out_valid, bus.in_ready, busy, bus.err, bus.out_data}, {3'b010, e});
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [4:0] got;
        logic [4:0] e;
        accept_word(4'b0011);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({bus.in_ready, bus.out_valid, busy} !== 3'b000) begin
                bad++;
                $display("FAIL reset_mid_hold got=%b required=000",
                         {bus.in_ready, bus.out_valid, busy});
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_no_valid got=%0d required=0", seen);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_ready got=%b required=1", bus.in_ready);
        end
        accept_word(4'b1110);
        wait_out(lat);
        take(got);
        e = exp_q.pop_front();
        total++;
        if (got !== e || got !== 5'b00010) begin
            bad++;
            $display("FAIL reset_mid_next got=%h required=%h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        int last;
        int accepts;
        logic [4:0] e;
        logic [3:0] d;
        logic chg;
        last = -1;
        accepts = 0;
        d = 4'h3;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        for (int c = 0; c < 42; c++) begin
            chg = 1'b0;
            if (bus.in_ready === 1'b1 && bus.out_valid === 1'b1) begin
                total++;
                bad++;
                $display("FAIL overlap cycle=%0d in_ready=1 out_valid=1 required exclusive", c);
            end
            if (bus.out_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected got=%h required=none", {bus.err, bus.out_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.err, bus.out_data} !== e) begin
                        bad++;
                        $display("FAIL b2b_decode got=%h required=%h", {bus.err, bus.out_data}, e);
                    end
                end
            end
            if (bus.in_ready === 1'b1) begin
                if (last >= 0) begin
                    total++;
                    if (c - last != 6) begin
                        bad++;
                        $display("FAIL b2b_spacing got=%0d required=6", c - last);
                    end
                end
                last = c;
                accepts++;
                exp_q.push_back(model(d));
                chg = 1'b1;
            end
            @(negedge clk);
            if (chg) begin
                d = d + 4'd5;
                bus.in_data = d;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (accepts != 7 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count accepts=%0d left=%0d required=7,0", accepts, exp_q.size());
        end
    endtask

`ifdef TWOS_DEC_ERR_STICKY_EN
    task automatic test_sticky();
        int lat;
        logic [4:0] got;
        accept_word(4'b0111);
        wait_out(lat);
        take(got);
        void'(exp_q.pop_front());
        accept_word(4'b1111);
        wait_out(lat);
        take(got);
        void'(exp_q.pop_front());
        total++;
        if (err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL sticky_set got=%b required=1", err_sticky);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++;
        if (err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL sticky_clear got=%b required=0", err_sticky);
        end
        accept_word(4'b0111);
        clr_err = 1'b1;
        wait_out(lat);
        total++;
        if (err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL sticky_set_wins got=%b required=1", err_sticky);
        end
        clr_err = 1'b0;
        take(got);
        void'(exp_q.pop_front());
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_all_values();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef TWOS_DEC_ERR_STICKY_EN
        test_sticky();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
